// File: rtl/mem_arbiter_if.sv
// Requester-side channel of mem_arbiter: one command port plus its read-return path.
// The master modport is the requester; the slave modport is the arbiter.
interface mem_arbiter_if #(
  parameter int AW = 32
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [3:0]    wmask;
  logic          gnt;
  logic          rvalid;
  logic [31:0]   rdata;

  modport master (
    output req, we, addr, wdata, wmask,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wmask,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (cpu, dbg) arbiter in front of a single-port memory with RD_LAT read latency.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority with cpu first.
module mem_arbiter #(
  parameter int RD_LAT = 1,
  parameter int AW     = 32
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   cpu,
  mem_arbiter_if.slave   dbg,
  output logic           mem_en_o,
  output logic           mem_we_o,
  output logic [AW-1:0]  mem_addr_o,
  output logic [31:0]    mem_wdata_o,
  output logic [3:0]     mem_wmask_o,
  input  logic [31:0]    mem_rdata_i,
  output logic           busy_o
);

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

  localparam int            CW       = 2;
  localparam logic [CW-1:0] LAT_LOAD = CW'(RD_LAT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  owner_t        owner_q, owner_d;

  logic cpu_pri;
  logic cpu_win;
  logic dbg_win;
  logic rd_done;

`ifdef MEM_ARB_RR_EN
  logic last_dbg_q, last_dbg_d;

  // cpu takes a conflict only when dbg was the most recent grantee.
  assign cpu_pri = last_dbg_q;

  always_comb begin
    last_dbg_d = last_dbg_q;
    if (dbg_win) begin
      last_dbg_d = 1'b1;
    end else if (cpu_win) begin
      last_dbg_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_dbg_q <= 1'b1;
    end else begin
      last_dbg_q <= last_dbg_d;
    end
  end
`else
  assign cpu_pri = 1'b1;
`endif

  // Grants are gated by rst so nothing is accepted while reset is held.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (state_q == IDLE && !rst) begin
      cpu_win = cpu.req && (!dbg.req || cpu_pri);
      dbg_win = dbg.req && !cpu_win;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    rd_done = 1'b0;
    case (state_q)
      IDLE: begin
        if ((cpu_win && !cpu.we) || (dbg_win && !dbg.we)) begin
          state_d = RD_WAIT;
          cnt_d   = LAT_LOAD;
          owner_d = dbg_win ? OWN_DBG : OWN_CPU;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= OWN_CPU;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wmask_o = '0;
    if (cpu_win) begin
      mem_we_o    = cpu.we;
      mem_addr_o  = cpu.addr;
      mem_wdata_o = cpu.wdata;
      mem_wmask_o = cpu.wmask;
    end else if (dbg_win) begin
      mem_we_o    = dbg.we;
      mem_addr_o  = dbg.addr;
      mem_wdata_o = dbg.wdata;
      mem_wmask_o = dbg.wmask;
    end
  end

  assign mem_en_o   = cpu_win || dbg_win;
  assign busy_o     = (state_q == RD_WAIT);
  assign cpu.gnt    = cpu_win;
  assign dbg.gnt    = dbg_win;
  assign cpu.rvalid = rd_done && (owner_q == OWN_CPU);
  assign dbg.rvalid = rd_done && (owner_q == OWN_DBG);
  assign cpu.rdata  = mem_rdata_i;
  assign dbg.rdata  = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: three instances (RD_LAT 1..3) checked every cycle
// against a cycle-index reference model, plus a vector table and directed corner cases.
module tb_mem_arbiter;

  localparam int AW   = 32;
  localparam int NDUT = 3;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
  } cmd_t;

  typedef struct {
    logic          c_req;
    cmd_t          c_cmd;
    logic          d_req;
    cmd_t          d_cmd;
    logic [1:0]    gnt;    // {cpu, dbg}
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wmask;
  } vec_t;

  localparam cmd_t NOC = '0;

  logic        clk;
  logic        rst;
  logic [31:0] mem_rdata;

  logic c_pend [NDUT];
  logic d_pend [NDUT];
  cmd_t c_cmd  [NDUT];
  cmd_t d_cmd  [NDUT];

  logic          c_gnt  [NDUT];
  logic          d_gnt  [NDUT];
  logic          c_rv   [NDUT];
  logic          d_rv   [NDUT];
  logic [31:0]   c_rd   [NDUT];
  logic [31:0]   d_rd   [NDUT];
  logic          m_en   [NDUT];
  logic          m_we   [NDUT];
  logic [AW-1:0] m_addr [NDUT];
  logic [31:0]   m_wdata[NDUT];
  logic [3:0]    m_wmask[NDUT];
  logic          bsy    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mem_arbiter_if #(.AW(AW)) cpu_if ();
    mem_arbiter_if #(.AW(AW)) dbg_if ();

    assign cpu_if.req   = c_pend[g];
    assign cpu_if.we    = c_cmd[g].we;
    assign cpu_if.addr  = c_cmd[g].addr;
    assign cpu_if.wdata = c_cmd[g].wdata;
    assign cpu_if.wmask = c_cmd[g].wmask;
    assign dbg_if.req   = d_pend[g];
    assign dbg_if.we    = d_cmd[g].we;
    assign dbg_if.addr  = d_cmd[g].addr;
    assign dbg_if.wdata = d_cmd[g].wdata;
    assign dbg_if.wmask = d_cmd[g].wmask;

    mem_arbiter #(.RD_LAT(g + 1), .AW(AW)) u_dut (
      .clk         (clk),
      .rst         (rst),
      .cpu         (cpu_if),
      .dbg         (dbg_if),
      .mem_en_o    (m_en[g]),
      .mem_we_o    (m_we[g]),
      .mem_addr_o  (m_addr[g]),
      .mem_wdata_o (m_wdata[g]),
      .mem_wmask_o (m_wmask[g]),
      .mem_rdata_i (mem_rdata),
      .busy_o      (bsy[g])
    );

    assign c_gnt[g] = cpu_if.gnt;
    assign d_gnt[g] = dbg_if.gnt;
    assign c_rv[g]  = cpu_if.rvalid;
    assign d_rv[g]  = dbg_if.rvalid;
    assign c_rd[g]  = cpu_if.rdata;
    assign d_rd[g]  = dbg_if.rdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Reference model: cycle index of the last accepted read (-1 when none in flight).
  int   rd_t     [NDUT];
  logic rd_own   [NDUT];
  logic last_dbg [NDUT];

  logic          sc_gnt [NDUT];
  logic          sd_gnt [NDUT];
  logic          sc_rv  [NDUT];
  logic          sd_rv  [NDUT];
  logic          s_en   [NDUT];
  logic          s_we   [NDUT];
  logic          s_bsy  [NDUT];
  logic [31:0]   sc_rd  [NDUT];
  logic [AW-1:0] s_addr [NDUT];
  logic [31:0]   s_wdata[NDUT];
  logic [3:0]    s_wmask[NDUT];

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] m);
    cmd_t c;
    c.we = 1'b1; c.addr = a; c.wdata = d; c.wmask = m;
    return c;
  endfunction

  function automatic cmd_t rd(input logic [AW-1:0] a);
    cmd_t c;
    c = '0;
    c.addr = a;
    return c;
  endfunction

  function automatic logic [6:0] ctl(input int i);
    return {c_gnt[i], d_gnt[i], c_rv[i], d_rv[i], m_en[i], m_we[i], bsy[i]};
  endfunction

  task automatic issue_c(input cmd_t c);
    for (int i = 0; i < NDUT; i++)
      if (!c_pend[i]) begin c_pend[i] = 1'b1; c_cmd[i] = c; end
  endtask

  task automatic issue_d(input cmd_t c);
    for (int i = 0; i < NDUT; i++)
      if (!d_pend[i]) begin d_pend[i] = 1'b1; d_cmd[i] = c; end
  endtask

  task automatic model_check(input int i);
    int   lat;
    bit   waiting;
    logic ec, ed, erc, erd;
    cmd_t sel;
    lat = i + 1;
    waiting = (rd_t[i] >= 0) && (cyc > rd_t[i]) && (cyc <= rd_t[i] + lat);
    ec = 1'b0; ed = 1'b0; erc = 1'b0; erd = 1'b0; sel = '0;
    if (waiting) begin
      erc = (cyc == rd_t[i] + lat) && !rd_own[i];
      erd = (cyc == rd_t[i] + lat) &&  rd_own[i];
    end else begin
      if (c_pend[i] && d_pend[i]) begin
`ifdef MEM_ARB_RR_EN
        ec = last_dbg[i];
`else
        ec = 1'b1;
`endif
        ed = !ec;
      end else begin
        ec = c_pend[i];
        ed = d_pend[i];
      end
      sel = ec ? c_cmd[i] : d_cmd[i];
    end
    check($sformatf("dut%0d ctl cyc%0d", i, cyc), ctl(i),
          {ec, ed, erc, erd, ec | ed, (ec | ed) & sel.we, waiting});
    if (ec || ed)
      check($sformatf("dut%0d bus cyc%0d", i, cyc), {m_addr[i], m_wdata[i], m_wmask[i]},
            {sel.addr, sel.wdata, sel.wmask});
    check($sformatf("dut%0d rdata cyc%0d", i, cyc), {c_rd[i], d_rd[i]}, {mem_rdata, mem_rdata});
    if (waiting && cyc == rd_t[i] + lat) rd_t[i] = -1;
    if (ec || ed) begin
      last_dbg[i] = ed;
      if (!sel.we) begin rd_t[i] = cyc; rd_own[i] = ed; end
    end
    sc_gnt[i] = c_gnt[i];  sd_gnt[i] = d_gnt[i];
    sc_rv[i]  = c_rv[i];   sd_rv[i]  = d_rv[i];
    s_en[i]   = m_en[i];   s_we[i]   = m_we[i];   s_bsy[i] = bsy[i];
    sc_rd[i]  = c_rd[i];   s_addr[i] = m_addr[i];
    s_wdata[i] = m_wdata[i]; s_wmask[i] = m_wmask[i];
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) model_check(i);
    cyc++;
    @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) begin
      if (sc_gnt[i]) c_pend[i] = 1'b0;
      if (sd_gnt[i]) d_pend[i] = 1'b0;
    end
  endtask

  task automatic reset_all();
    rst = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      rd_t[i] = -1; rd_own[i] = 1'b0; last_dbg[i] = 1'b1;
      sc_gnt[i] = 1'b0; sd_gnt[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < NDUT; i++)
      check($sformatf("dut%0d reset ctl", i), ctl(i), 7'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic apply_vec(input int k);
    for (int i = 0; i < NDUT; i++) begin
      c_pend[i] = vecs[k].c_req; c_cmd[i] = vecs[k].c_cmd;
      d_pend[i] = vecs[k].d_req; d_cmd[i] = vecs[k].d_cmd;
    end
    @(negedge clk);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("vec%0d dut%0d ctl", k, i), {c_gnt[i], d_gnt[i], m_en[i], m_we[i], bsy[i]},
            {vecs[k].gnt, vecs[k].en, vecs[k].we, 1'b0});
      if (vecs[k].en)
        check($sformatf("vec%0d dut%0d bus", k, i), {m_addr[i], m_wdata[i], m_wmask[i]},
              {vecs[k].addr, vecs[k].wdata, vecs[k].wmask});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, miscompares=%0d", miscompares);
    $fatal(1);
  end

  initial begin
    logic exp_c;
    rst = 1'b1;
    mem_rdata = 32'h0;
    for (int i = 0; i < NDUT; i++) begin
      c_pend[i] = 1'b0; d_pend[i] = 1'b0; c_cmd[i] = NOC; d_cmd[i] = NOC;
    end

    // Vector table: IDLE-state write arbitration, starting from the reset pointer.
    vecs[0] = '{1'b0, NOC, 1'b0, NOC, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};
    vecs[1] = '{1'b1, wr(32'h10, 32'hA1, 4'hF), 1'b0, NOC, 2'b10, 1'b1, 1'b1, 32'h10, 32'hA1, 4'hF};
    vecs[2] = '{1'b0, NOC, 1'b1, wr(32'h24, 32'hB2, 4'h3), 2'b01, 1'b1, 1'b1, 32'h24, 32'hB2, 4'h3};
    vecs[3] = '{1'b1, wr(32'h30, 32'hC3, 4'h1), 1'b1, wr(32'h34, 32'hD4, 4'h8),
                2'b10, 1'b1, 1'b1, 32'h30, 32'hC3, 4'h1};
`ifdef MEM_ARB_RR_EN
    vecs[4] = '{1'b1, wr(32'h38, 32'hE5, 4'h2), 1'b1, wr(32'h34, 32'hD4, 4'h8),
                2'b01, 1'b1, 1'b1, 32'h34, 32'hD4, 4'h8};
    vecs[5] = '{1'b1, wr(32'h38, 32'hE5, 4'h2), 1'b0, NOC, 2'b10, 1'b1, 1'b1, 32'h38, 32'hE5, 4'h2};
`else
    vecs[4] = '{1'b1, wr(32'h38, 32'hE5, 4'h2), 1'b1, wr(32'h34, 32'hD4, 4'h8),
                2'b10, 1'b1, 1'b1, 32'h38, 32'hE5, 4'h2};
    vecs[5] = '{1'b0, NOC, 1'b1, wr(32'h34, 32'hD4, 4'h8), 2'b01, 1'b1, 1'b1, 32'h34, 32'hD4, 4'h8};
`endif
    vecs[6] = '{1'b1, wr(32'h3C, 32'hF6, 4'h0), 1'b0, NOC, 2'b10, 1'b1, 1'b1, 32'h3C, 32'hF6, 4'h0};
    vecs[7] = '{1'b0, NOC, 1'b0, NOC, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0};

    reset_all();
    for (int k = 0; k < 8; k++) apply_vec(k);
    for (int i = 0; i < NDUT; i++) begin c_pend[i] = 1'b0; d_pend[i] = 1'b0; end

    // cpu read at 0x100 with RD_LAT=1 returning 0xDEADBEEF.
    reset_all();
    mem_rdata = 32'h5555_AAAA;
    issue_c(rd(32'h100));
    step();
    check("r027 gnt at t", {sc_gnt[0], s_en[0], s_we[0], s_addr[0]}, {3'b110, 32'h100});
    mem_rdata = 32'hDEAD_BEEF;
    step();
    check("r027 rvalid at t+1", {sc_rv[0], s_bsy[0], sc_rd[0]}, {2'b11, 32'hDEAD_BEEF});
    mem_rdata = 32'h0;
    step();
    check("r027 idle at t+2", {s_bsy[0], sc_rv[0]}, 2'b00);

    // Both requesters issue writes for four cycles.
    reset_all();
    for (int k = 0; k < 4; k++) begin
      issue_c(wr(32'h200 + k, 32'h1000 + k, 4'hF));
      issue_d(wr(32'h300 + k, 32'h2000 + k, 4'hF));
      step();
`ifdef MEM_ARB_RR_EN
      exp_c = (k % 2 == 0);
`else
      exp_c = 1'b1;
`endif
      check($sformatf("r028 grant k%0d", k), {sc_gnt[0], sd_gnt[0], s_en[0]}, {exp_c, !exp_c, 1'b1});
    end
    for (int i = 0; i < NDUT; i++) begin c_pend[i] = 1'b0; d_pend[i] = 1'b0; end

    // RD_LAT=3: dbg read at t, cpu write waiting from t+1.
    reset_all();
    issue_d(rd(32'h40));
    step();
    check("r030 dbg gnt at t", {sd_gnt[2], sc_gnt[2]}, 2'b10);
    issue_c(wr(32'h44, 32'hCAFE_0001, 4'hF));
    for (int k = 1; k <= 4; k++) begin
      mem_rdata = $urandom;
      step();
      check($sformatf("r030 t+%0d", k), {sd_rv[2], sc_gnt[2]}, {k == 3, k == 4});
    end

    // Reset in the middle of a RD_LAT=2 read.
    reset_all();
    issue_c(rd(32'h80));
    step();
    check("r031 busy at t+1", bsy[1], 1'b1);
    reset_all();
    check("r031 no rvalid at t+2", {c_rv[1], d_rv[1], bsy[1]}, 3'b000);
    issue_d(wr(32'h88, 32'h1234_5678, 4'hC));
    step();
    check("r031 gnt after rst", {sd_gnt[1], s_en[1]}, 2'b11);

    // Masked single-cycle write.
    reset_all();
    issue_c(wr(32'h20, 32'h1122_3344, 4'b0101));
    step();
    check("r032 bus", {s_en[0], s_we[0], s_wmask[0], s_wdata[0], s_addr[0]},
          {2'b11, 4'b0101, 32'h1122_3344, 32'h20});
    step();
    check("r032 single cycle", {s_en[0], s_we[0]}, 2'b00);

    // Randomized traffic with occasional resets.
    reset_all();
    for (int n = 0; n < 2400; n++) begin
      if (n % 800 == 799) reset_all();
      mem_rdata = $urandom;
      for (int i = 0; i < NDUT; i++) begin
        if (!c_pend[i] && $urandom_range(0, 9) < 5) begin
          c_pend[i] = 1'b1;
          c_cmd[i] = '{we: ($urandom_range(0, 2) != 0), addr: $urandom, wdata: $urandom,
                       wmask: 4'($urandom_range(0, 15))};
        end
        if (!d_pend[i] && $urandom_range(0, 9) < 5) begin
          d_pend[i] = 1'b1;
          d_cmd[i] = '{we: ($urandom_range(0, 2) != 0), addr: $urandom, wdata: $urandom,
                       wmask: 4'($urandom_range(0, 15))};
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter RD_LAT, default 1, meaning memory read latency in cycles (legal 1..4).
REQ-002 SHALL have parameter AW, default 32, meaning address width.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have, per requester p in {cpu, dbg}: p_req input 1 (access request), p_we input 1 (write), p_addr input AW, p_wdata input 32, p_wmask input 4 (byte enables).
REQ-006 SHALL have, per requester: p_gnt output 1 (command accepted this cycle), p_rvalid output 1 (read data valid), p_rdata output 32.
REQ-007 SHALL have memory side: mem_en output 1, mem_we output 1, mem_addr output AW, mem_wdata output 32, mem_wmask output 4, mem_rdata input 32.
REQ-008 SHALL have port busy  output  1  high while a read is outstanding.

Function
REQ-009 SHALL implement FSM states IDLE and RD_WAIT.
REQ-010 In IDLE with at least one req high, SHALL select one winner combinationally and assert its gnt, mem_en=1 and drive mem_we/addr/wdata/wmask from that requester in the same cycle.
REQ-011 A requester SHALL hold req and its command fields stable until it sees gnt; gnt is a one-cycle pulse per accepted command.
REQ-012 A granted write SHALL complete at the gnt edge; FSM stays IDLE, so back-to-back writes sustain one per cycle.
REQ-013 A granted read at cycle t SHALL move the FSM to RD_WAIT, load the latency counter, and record the owner.
REQ-014 The owner's rvalid SHALL be high exactly in cycle t+RD_LAT, with p_rdata = mem_rdata in that cycle; the FSM returns to IDLE the following cycle.
REQ-015 In RD_WAIT SHALL assert no gnt and mem_en=0; requests arriving then wait.
REQ-016 Read throughput SHALL be one read per RD_LAT+1 cycles.
REQ-017 The non-owner's rvalid SHALL stay 0; both p_rdata outputs SHALL carry mem_rdata (meaningful only with rvalid).
REQ-018 With no req in IDLE, mem_en=0 and all gnt=0.
REQ-019 mem_we SHALL be 0 whenever mem_en is 0.
REQ-020 busy SHALL equal (state == RD_WAIT).

Reset
REQ-021 On rst SHALL enter IDLE immediately, clear counter and owner; gnt, rvalid, mem_en, mem_we, busy all 0.
REQ-022 Reset during RD_WAIT SHALL discard the outstanding read; no rvalid is ever produced for it.
REQ-023 Round-robin pointer (when compiled in) SHALL reset to "dbg last granted".

Configuration
REQ-024 Macro MEM_ARB_RR_EN SHALL select arbitration policy.
REQ-025 Without MEM_ARB_RR_EN: fixed priority, cpu wins every conflict.
REQ-026 With MEM_ARB_RR_EN: on conflict, the requester not most recently granted wins; pointer updates on every gnt (read or write); with a single requester it is always granted.

Verification
REQ-027 cpu read addr 0x100, RD_LAT=1, mem returns 0xDEADBEEF -> cpu_gnt at t, cpu_rvalid at t+1 with 0xDEADBEEF, busy high at t+1, IDLE at t+2.
REQ-028 cpu and dbg writes both asserted for 4 cycles, no macro -> cpu_gnt in cycles 0..3, dbg_gnt 0, mem_en high every cycle.
REQ-029 Same stimulus with MEM_ARB_RR_EN -> grants alternate cpu, dbg, cpu, dbg.
REQ-030 RD_LAT=3, dbg read at t, cpu write request at t+1 -> cpu_gnt first at t+4, dbg_rvalid only at t+3.
REQ-031 rst asserted at t+1 of a RD_LAT=2 read -> no rvalid at t+2, busy 0 immediately, next req granted the first cycle after rst deasserts.
REQ-032 Write with wmask=4'b0101, data 0x11223344, addr 0x20 -> single cycle mem_en=1, mem_we=1, mem_wmask=0101, mem_wdata=0x11223344, mem_addr=0x20.
